// File: rtl/cronometro_pkg.sv
// Shared stopwatch constants: state codes, estado width, BCD digit limits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cronometro_pkg;

   localparam int ESTADO_W = 3;

   // State codes shared with the stopwatch state machine
   typedef enum logic [ESTADO_W-1:0] {
      INICIO = 3'd0,
      CONTAR = 3'd1,
      PAUSAR = 3'd2,
      PARAR  = 3'd3
   } estado_t;

   // Upper limit of each BCD digit in MM:SS.CC
   localparam logic [3:0] MAX_CEN_U = 4'd9;
   localparam logic [3:0] MAX_CEN_D = 4'd9;
   localparam logic [3:0] MAX_SEG_U = 4'd9;
   localparam logic [3:0] MAX_SEG_D = 4'd5;
   localparam logic [3:0] MAX_MIN_U = 4'd9;
   localparam logic [3:0] MAX_MIN_D = 4'd5;

   // Six BCD digits, most significant first
   typedef struct packed {
      logic [3:0] min_d;
      logic [3:0] min_u;
      logic [3:0] seg_d;
      logic [3:0] seg_u;
      logic [3:0] cen_d;
      logic [3:0] cen_u;
   } tempo_t;

   // True when every digit sits at its limit (59:59.99)
   function automatic logic tempo_no_limite(input tempo_t t);
      return (t.min_d == MAX_MIN_D) && (t.min_u == MAX_MIN_U) &&
             (t.seg_d == MAX_SEG_D) && (t.seg_u == MAX_SEG_U) &&
             (t.cen_d == MAX_CEN_D) && (t.cen_u == MAX_CEN_U);
   endfunction

endpackage

// File: rtl/digito_bcd.sv
// One BCD digit of the carry chain; wraps at MAX and carries out.
// Latency: q updates on the edge after cin; cout is combinational.
// Backpressure: none; cin is a one-cycle enable.
module digito_bcd
   import cronometro_pkg::*;
#(
   parameter logic [3:0] MAX = MAX_CEN_U
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       cin,
   output logic [3:0] q,
   output logic       cout
);

   logic [3:0] r_q;

   // Digit register: reset/clear to 0, otherwise step on carry-in with wrap at MAX
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_q <= 4'd0;
      end else if (clr) begin
         r_q <= 4'd0;
      end else if (cin) begin
         r_q <= (r_q == MAX) ? 4'd0 : r_q + 4'd1;
      end
   end

   assign q    = r_q;
   assign cout = cin && (r_q == MAX);

endmodule

// File: rtl/contador_tempo.sv
// Stopwatch timekeeping: prescaler -> centisecond tick -> BCD MM:SS.CC chain -> display register.
// Latency: tick DIV cycles after counting starts; live digits step one cycle after tick; display one cycle behind live.
// Backpressure: none; enable=0 freezes the display while live time keeps running.
module contador_tempo
   import cronometro_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 100
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ESTADO_W-1:0] estado,
   input  logic                contando,
   input  logic                enable,
   output logic [3:0]          min_d,
   output logic [3:0]          min_u,
   output logic [3:0]          seg_d,
   output logic [3:0]          seg_u,
   output logic [3:0]          cen_d,
   output logic [3:0]          cen_u,
   output logic                tick,
   output logic                estouro
);

   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PRE_W-1:0] r_pre;
   logic             r_tick;
   logic             r_estouro;
   tempo_t           r_disp;

   logic             w_clr;
   logic             w_pre_wrap;
   logic [6:0]       w_carry;
   tempo_t           w_live;

   assign w_clr      = (estado == INICIO);
   assign w_pre_wrap = contando && (r_pre == PRE_W'(DIV - 1));

   // Prescaler: runs while counting, holds the sub-tick fraction across pauses
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pre <= '0;
      end else if (w_clr) begin
         r_pre <= '0;
      end else if (contando) begin
         r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
      end
   end

   // tick/estouro registers. Live time cannot move on the edge that raises tick
   // (tick is never back-to-back), so the current digits decide the wrap.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_tick    <= 1'b0;
         r_estouro <= 1'b0;
      end else if (w_clr) begin
         r_tick    <= 1'b0;
         r_estouro <= 1'b0;
      end else begin
         r_tick    <= w_pre_wrap;
         r_estouro <= w_pre_wrap && tempo_no_limite(w_live);
      end
   end

   // Live BCD carry chain, least significant digit first
   assign w_carry[0] = r_tick;

   digito_bcd #(.MAX(MAX_CEN_U)) u_cen_u (
      .clk(clk), .reset(reset), .clr(w_clr), .cin(w_carry[0]), .q(w_live.cen_u), .cout(w_carry[1])
   );
   digito_bcd #(.MAX(MAX_CEN_D)) u_cen_d (
      .clk(clk), .reset(reset), .clr(w_clr), .cin(w_carry[1]), .q(w_live.cen_d), .cout(w_carry[2])
   );
   digito_bcd #(.MAX(MAX_SEG_U)) u_seg_u (
      .clk(clk), .reset(reset), .clr(w_clr), .cin(w_carry[2]), .q(w_live.seg_u), .cout(w_carry[3])
   );
   digito_bcd #(.MAX(MAX_SEG_D)) u_seg_d (
      .clk(clk), .reset(reset), .clr(w_clr), .cin(w_carry[3]), .q(w_live.seg_d), .cout(w_carry[4])
   );
   digito_bcd #(.MAX(MAX_MIN_U)) u_min_u (
      .clk(clk), .reset(reset), .clr(w_clr), .cin(w_carry[4]), .q(w_live.min_u), .cout(w_carry[5])
   );
   digito_bcd #(.MAX(MAX_MIN_D)) u_min_d (
      .clk(clk), .reset(reset), .clr(w_clr), .cin(w_carry[5]), .q(w_live.min_d), .cout(w_carry[6])
   );

   // The registered estouro must coincide with the chain's own overflow carry
   a_estouro_carry: assert property (@(posedge clk) disable iff (!reset)
      r_estouro == w_carry[6]);

   // Display register: tracks live time while enabled, freezes for lap view otherwise
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_disp <= '0;
      end else if (enable) begin
         r_disp <= w_live;
      end
   end

   assign min_d   = r_disp.min_d;
   assign min_u   = r_disp.min_u;
   assign seg_d   = r_disp.seg_d;
   assign seg_u   = r_disp.seg_u;
   assign cen_d   = r_disp.cen_d;
   assign cen_u   = r_disp.cen_u;
   assign tick    = r_tick;
   assign estouro = r_estouro;

endmodule

// File: tb/tb_contador_tempo.sv
// Bench for contador_tempo: scoreboard against a centisecond-integer reference model.
// Latency: expectations are queued at the driving negedge and checked after the following posedge.
// Backpressure: n/a.
module tb_contador_tempo;

   localparam int CLK_HZ  = 1000;
   localparam int TICK_HZ = 100;
   localparam int DIV     = CLK_HZ / TICK_HZ;
   localparam int WRAP    = 60 * 60 * 100;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] estado = 3'd0;
   logic       contando = 1'b0;
   logic       enable = 1'b0;
   logic [3:0] min_d, min_u, seg_d, seg_u, cen_d, cen_u;
   logic       tick, estouro;

   always #5 clk = ~clk;

   contador_tempo #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
      .clk(clk), .reset(reset), .estado(estado), .contando(contando), .enable(enable),
      .min_d(min_d), .min_u(min_u), .seg_d(seg_d), .seg_u(seg_u), .cen_d(cen_d), .cen_u(cen_u),
      .tick(tick), .estouro(estouro)
   );

   // {tick, estouro, pre[3:0], live[23:0], display[23:0]}
   typedef logic [53:0] obs_t;
   obs_t exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   int tick_cnt = 0;

   // Reference model: time as a plain centisecond count
   int m_pre  = 0;
   int m_time = 0;
   int m_disp = 0;
   bit m_tick = 1'b0;
   bit m_est  = 1'b0;

   function automatic logic [23:0] to_bcd(input int t);
      int mm, ss, cc;
      mm = t / 6000;
      ss = (t / 100) % 60;
      cc = t % 100;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
   endfunction

   function automatic logic [23:0] live_now();
      return {dut.u_min_d.q, dut.u_min_u.q, dut.u_seg_d.q, dut.u_seg_u.q, dut.u_cen_d.q, dut.u_cen_u.q};
   endfunction

   task automatic model_edge(input bit rst, input logic [2:0] est, input bit cont, input bit en);
      int  nt, nd;
      bit  ntk;
      if (!rst) begin
         m_pre = 0; m_time = 0; m_disp = 0; m_tick = 1'b0; m_est = 1'b0;
      end else begin
         nd = en ? m_time : m_disp;
         if (est == 3'd0) begin
            m_pre = 0; m_time = 0; m_tick = 1'b0; m_est = 1'b0;
         end else begin
            nt     = m_tick ? (m_time + 1) % WRAP : m_time;
            ntk    = cont && (m_pre == DIV - 1);
            m_est  = ntk && (nt == WRAP - 1);
            m_pre  = cont ? (m_pre + 1) % DIV : m_pre;
            m_time = nt;
            m_tick = ntk;
         end
         m_disp = nd;
      end
   endtask

   task automatic step(input bit rst, input logic [2:0] est, input bit cont, input bit en);
      @(negedge clk);
      reset = rst; estado = est; contando = cont; enable = en;
      model_edge(rst, est, cont, en);
      exp_q.push_back({m_tick, m_est, 4'(m_pre), to_bcd(m_time), to_bcd(m_disp)});
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: every sampled cycle is compared with the oldest queued expectation
   initial begin
      obs_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (tick === 1'b1) tick_cnt++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {tick, estouro, dut.r_pre, live_now(), min_d, min_u, seg_d, seg_u, cen_d, cen_u};
            n_tests++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL scoreboard t=%0t actual=%h required=%h", $time, a, e);
            end
         end
      end
   end

   initial begin
      int guard, t0, k, n_est;

      // Basic count from reset
      repeat (3) step(1'b0, 3'd1, 1'b1, 1'b1);
      t0 = tick_cnt;
      repeat (1000) step(1'b1, 3'd1, 1'b1, 1'b1);
      settle();
      check("tick_count_1000", 64'(tick_cnt - t0), 64'd100);
      repeat (2) step(1'b1, 3'd1, 1'b1, 1'b1);
      settle();
      check("display_after_1s", {min_d, min_u, seg_d, seg_u, cen_d, cen_u}, to_bcd(100));

      // Reset held mid-count
      repeat (37) step(1'b1, 3'd1, 1'b1, 1'b1);
      repeat (3) step(1'b0, 3'd1, 1'b1, 1'b1);
      settle();
      check("reset_live", live_now(), 24'h0);
      check("reset_display", {min_d, min_u, seg_d, seg_u, cen_d, cen_u}, 24'h0);
      check("reset_tick_estouro", {tick, estouro}, 2'b00);

      // Lap freeze at 00:00.50
      guard = 0;
      while (m_time != 50 && guard < 1000) begin
         step(1'b1, 3'd1, 1'b1, 1'b1);
         guard++;
      end
      check("lap_reach_timeout", 64'(guard < 1000), 64'd1);
      step(1'b1, 3'd1, 1'b1, 1'b1);
      repeat (300) step(1'b1, 3'd2, 1'b1, 1'b0);
      settle();
      check("lap_display_frozen", {min_d, min_u, seg_d, seg_u, cen_d, cen_u}, to_bcd(50));
      check("lap_live_running", live_now(), to_bcd(80));
      step(1'b1, 3'd1, 1'b1, 1'b1);
      settle();
      check("lap_release", {min_d, min_u, seg_d, seg_u, cen_d, cen_u}, to_bcd(80));

      // Stop with pre=6, resume: next tick after exactly 4 cycles
      guard = 0;
      while (m_pre != 6 && guard < 50) begin
         step(1'b1, 3'd1, 1'b1, 1'b1);
         guard++;
      end
      repeat (50) step(1'b1, 3'd3, 1'b0, 1'b1);
      k = 0;
      guard = 0;
      while (guard < 20) begin
         step(1'b1, 3'd1, 1'b1, 1'b1);
         settle();
         guard++;
         if (tick === 1'b1) begin
            k = guard;
            break;
         end
      end
      check("resume_tick_delay", 64'(k), 64'd4);

      // Wrap 59:59.99 -> 00:00.00
      repeat (3) step(1'b1, 3'd3, 1'b0, 1'b1);
      settle();
      force dut.u_min_d.r_q = 4'd5;
      force dut.u_min_u.r_q = 4'd9;
      force dut.u_seg_d.r_q = 4'd5;
      force dut.u_seg_u.r_q = 4'd9;
      force dut.u_cen_d.r_q = 4'd9;
      force dut.u_cen_u.r_q = 4'd9;
      m_time = WRAP - 1;
      step(1'b1, 3'd3, 1'b0, 1'b1);
      settle();
      release dut.u_min_d.r_q;
      release dut.u_min_u.r_q;
      release dut.u_seg_d.r_q;
      release dut.u_seg_u.r_q;
      release dut.u_cen_d.r_q;
      release dut.u_cen_u.r_q;
      n_est = 0;
      k = 0;
      repeat (2 * DIV + 2) begin
         step(1'b1, 3'd1, 1'b1, 1'b1);
         settle();
         if (estouro === 1'b1) begin
            n_est++;
            if (tick === 1'b1) k++;
         end
      end
      check("wrap_estouro_pulses", 64'(n_est), 64'd1);
      check("wrap_estouro_with_tick", 64'(k), 64'd1);

      // Clear on the edge where the prescaler would raise tick
      guard = 0;
      while (!(m_pre == DIV - 1 && !m_tick) && guard < 30) begin
         step(1'b1, 3'd1, 1'b1, 1'b1);
         guard++;
      end
      step(1'b1, 3'd0, 1'b1, 1'b1);
      settle();
      check("clear_no_tick", {tick, estouro}, 2'b00);
      check("clear_pre", 64'(dut.r_pre), 64'd0);
      check("clear_live", live_now(), 24'h0);

      // Clear on the edge where a pending tick would advance live time
      repeat (25) step(1'b1, 3'd1, 1'b1, 1'b1);
      guard = 0;
      while (!m_tick && guard < 30) begin
         step(1'b1, 3'd1, 1'b1, 1'b1);
         guard++;
      end
      step(1'b1, 3'd0, 1'b1, 1'b1);
      settle();
      check("clear_over_increment", live_now(), 24'h0);

      // Randomised traffic, including illegal estado codes
      repeat (3000) begin
         step(($urandom_range(0, 299) != 0),
              ($urandom_range(0, 24) == 0) ? 3'd0 : 3'($urandom_range(1, 7)),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0));
      end

      step(1'b1, 3'd3, 1'b0, 1'b1);
      settle();
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
